// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/step/halt controller: FSM state encoding,
// default divisor and debounce constants, and a counter-width helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package cpu_run_ctrl_pkg;

    // Encodings are visible on state_o, so the values are fixed explicitly.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_HALT = 2'd3
    } state_e;

    localparam int unsigned DEF_FAST_DIV  = 4;
    localparam int unsigned DEF_SLOW_DIV  = 50_000_000;
    localparam int unsigned DEF_DB_CYCLES = 1_000_000;
    localparam int unsigned DEF_CNT_W     = 32;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board/CPU side signal bundle of the run controller.
// Latency: n/a (wires only). Backpressure: none; cpu_ce is a one-cycle enable.
// master: the controller (takes switches/buttons/halt_req, drives cpu_ce,
//         led_clk, state_o, cycle_cnt). slave: the board/CPU side.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import cpu_run_ctrl_pkg::*;

    logic             run_sw;      // 1 = free-run, 0 = single-step (async)
    logic             fast_sw;     // 1 = fast divisor, 0 = slow divisor (async)
    logic             step_btn;    // raw step button, active-high
    logic             resume_btn;  // raw resume-from-halt button, active-high
    logic             halt_req;    // CPU halt request, synchronous
    logic             cpu_ce;      // one-cycle CPU clock enable
    logic             led_clk;     // toggles once per cpu_ce
    state_e           state_o;     // current controller state
    logic [CNT_W-1:0] cycle_cnt;   // number of cpu_ce pulses issued

    modport master (
        input  run_sw, fast_sw, step_btn, resume_btn, halt_req,
        output cpu_ce, led_clk, state_o, cycle_cnt
    );

    modport slave (
        output run_sw, fast_sw, step_btn, resume_btn, halt_req,
        input  cpu_ce, led_clk, state_o, cycle_cnt
    );

endinterface

// File: rtl/cpu_run_ctrl_btn_pulse.sv
// Button conditioner: 2-flop sync, debounce (DB_CYCLES stable), rising one-shot.
// Latency: pulse 2 + DB_CYCLES cycles after the raw press first samples high.
// Backpressure: none; one btn_pulse per accepted press, short bounces dropped.
// Ports: clk_in/rst (sync, active-high), btn_raw (async button), btn_pulse.
module cpu_run_ctrl_btn_pulse
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int unsigned       DB_W   = cnt_w(DB_CYCLES);
    localparam logic [DB_W-1:0]   DB_TOP = DB_W'(DB_CYCLES - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            stable_q, stable_d;   // debounced button level
    logic            pulse_q, pulse_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;   // cycles the synced level has disagreed

    always_comb begin
        s1_d     = btn_raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        pulse_d  = 1'b0;
        if (s2_q == stable_q) begin
            // Any return to the accepted level restarts the stability window.
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_TOP) begin
            stable_d = s2_q;
            db_cnt_d = '0;
            pulse_d  = s2_q;   // only a newly accepted press fires
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller producing a registered one-cycle CPU clock enable.
// Latency: first RUN cpu_ce DIV cycles after RUN entry; STEP cpu_ce the cycle after the one-shot.
// Backpressure: none; halt_req stalls cpu_ce until a resume press.
// Ports: clk_in, rst (sync, active-high), io (cpu_run_ctrl_if.master: switches,
//        buttons, halt_req in; cpu_ce, led_clk, state_o, cycle_cnt out).
// Build option: CPU_CYCLE_COUNT_EN enables the saturating cycle_cnt counter;
//               otherwise cycle_cnt is tied to zero.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned FAST_DIV  = DEF_FAST_DIV,
    parameter int unsigned SLOW_DIV  = DEF_SLOW_DIV,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic              clk_in,
    input  logic              rst,
    cpu_run_ctrl_if.master    io
);

    localparam int unsigned      DIV_W    = cnt_w((FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV);
    localparam logic [DIV_W-1:0] FAST_TOP = DIV_W'(FAST_DIV - 1);
    localparam logic [DIV_W-1:0] SLOW_TOP = DIV_W'(SLOW_DIV - 1);

    // ---------------- switch synchronisers ----------------
    logic run_s1_q, run_s2_q;
    logic fast_s1_q, fast_s2_q, fast_s3_q;   // s3 only for change detection

    always_ff @(posedge clk_in) begin
        if (rst) begin
            run_s1_q  <= 1'b0;
            run_s2_q  <= 1'b0;
            fast_s1_q <= 1'b0;
            fast_s2_q <= 1'b0;
            fast_s3_q <= 1'b0;
        end else begin
            run_s1_q  <= io.run_sw;
            run_s2_q  <= run_s1_q;
            fast_s1_q <= io.fast_sw;
            fast_s2_q <= fast_s1_q;
            fast_s3_q <= fast_s2_q;
        end
    end

    // ---------------- button conditioners ----------------
    logic step_pls;
    logic resume_pls;

    cpu_run_ctrl_btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_step_btn (
        .clk_in    (clk_in),
        .rst       (rst),
        .btn_raw   (io.step_btn),
        .btn_pulse (step_pls)
    );

    cpu_run_ctrl_btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_resume_btn (
        .clk_in    (clk_in),
        .rst       (rst),
        .btn_raw   (io.resume_btn),
        .btn_pulse (resume_pls)
    );

    // ---------------- rate divider ----------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] div_top;
    logic [DIV_W-1:0] div_cur;
    logic             fast_chg;
    logic             tick;

    // A rate change restarts the count in the same cycle, as if RUN had just
    // been entered, so the new rate's first pulse lands a full period later.
    always_comb begin
        div_top  = fast_s2_q ? FAST_TOP : SLOW_TOP;
        fast_chg = fast_s2_q ^ fast_s3_q;
        div_cur  = fast_chg ? '0 : div_cnt_q;
        tick     = (div_cur == div_top);
    end

    // ---------------- control FSM ----------------
    state_e state_q, state_d;
    logic   cpu_ce_q, cpu_ce_d;   // cpu_ce_d is the enable for the next cycle
    logic   led_q, led_d;

    always_comb begin
        state_d   = state_q;
        cpu_ce_d  = 1'b0;
        div_cnt_d = '0;           // held at zero outside RUN, so RUN entry starts at 0
        led_d     = led_q ^ cpu_ce_q;
        case (state_q)
            S_IDLE: begin
                if (io.halt_req) begin
                    state_d = S_HALT;
                end else if (run_s2_q) begin
                    state_d = S_RUN;
                end else if (step_pls) begin
                    state_d  = S_STEP;
                    cpu_ce_d = 1'b1;
                end
            end
            S_RUN: begin
                // Leaving RUN drops a coincident tick rather than issuing it.
                if (io.halt_req) begin
                    state_d = S_HALT;
                end else if (!run_s2_q) begin
                    state_d = S_IDLE;
                end else begin
                    cpu_ce_d  = tick;
                    div_cnt_d = tick ? '0 : div_cur + DIV_W'(1);
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            S_HALT: begin
                // Resume steps past the halting instruction; step presses are ignored.
                if (resume_pls) begin
                    state_d  = S_STEP;
                    cpu_ce_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cpu_ce_q  <= 1'b0;
            led_q     <= 1'b0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cpu_ce_q  <= cpu_ce_d;
            led_q     <= led_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign io.cpu_ce  = cpu_ce_q;
    assign io.led_clk = led_q;
    assign io.state_o = state_q;

    // ---------------- pulse counter ----------------
`ifdef CPU_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (cpu_ce_q && (cyc_cnt_q != '1)) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cyc_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign io.cycle_cnt = cyc_cnt_q;
`else
    assign io.cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with small divisors and debounce window.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam int unsigned FAST = 2;
    localparam int unsigned SLOW = 5;
    localparam int unsigned DB   = 3;
    localparam int unsigned CW   = 3;

`ifdef CPU_CYCLE_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    always #5 clk_in = ~clk_in;

    cpu_run_ctrl_if #(.CNT_W(CW)) io ();

    cpu_run_ctrl #(
        .FAST_DIV  (FAST),
        .SLOW_DIV  (SLOW),
        .DB_CYCLES (DB),
        .CNT_W     (CW)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .io     (io)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected cycle_cnt after a given number of issued pulses (3-bit, saturating).
    function automatic logic [31:0] exp_cnt(input int pulses);
        if (!CNT_ON) return 32'd0;
        return (pulses > 7) ? 32'd7 : 32'(pulses);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    // Cycles until cpu_ce is seen; returns 999 if the bound expires.
    task automatic wait_ce(input int max_cyc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!io.cpu_ce && n < max_cyc);
        if (!io.cpu_ce) n = 999;
    endtask

    task automatic count_ce(input int cyc, output int c);
        c = 0;
        for (int i = 0; i < cyc; i++) begin
            tick();
            if (io.cpu_ce) c++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int c;
        int c2;
        io.run_sw     = 1'b0;
        io.fast_sw    = 1'b0;
        io.step_btn   = 1'b0;
        io.resume_btn = 1'b0;
        io.halt_req   = 1'b0;
        repeat (3) tick();

        // Reset state
        chk_eq("rst_ce",    32'(io.cpu_ce),    0);
        chk_eq("rst_led",   32'(io.led_clk),   0);
        chk_eq("rst_cnt",   32'(io.cycle_cnt), 0);
        chk_eq("rst_state", 32'(io.state_o),   0);
        rst = 1'b0;

        // 1: slow free-run
        io.run_sw = 1'b1;
        repeat (3) tick();
        chk_eq("t1_state", 32'(io.state_o), 1);
        wait_ce(20, n);
        chk_eq("t1_first", 32'(n), 5);
        tick();
        chk_eq("t1_led", 32'(io.led_clk), 1);
        wait_ce(20, n);
        chk_eq("t1_period", 32'(n), 4);
        io.run_sw = 1'b0;
        repeat (3) tick();
        chk_eq("t1_idle", 32'(io.state_o), 0);
        chk_eq("t1_cnt", 32'(io.cycle_cnt), exp_cnt(2));

        // 2: single step, glitch rejection
        io.step_btn = 1'b1;
        tick();
        tick();
        io.step_btn = 1'b0;
        count_ce(12, c);
        chk_eq("t2_glitch", 32'(c), 0);
        chk_eq("t2_glitch_st", 32'(io.state_o), 0);
        io.step_btn = 1'b1;
        wait_ce(20, n);
        chk_eq("t2_lat", 32'(n), 6);
        chk_eq("t2_step_st", 32'(io.state_o), 2);
        tick();
        chk_eq("t2_after_st", 32'(io.state_o), 0);
        repeat (3) tick();
        io.step_btn = 1'b0;
        count_ce(12, c);
        chk_eq("t2_single", 32'(c), 0);

        // 3: halt on a tick cycle, step ignored, resume steps once then runs
        io.run_sw = 1'b1;
        wait_ce(20, n);
        chk_eq("t3_run_first", 32'(n), 8);
        repeat (4) tick();
        io.halt_req = 1'b1;
        tick();
        io.halt_req = 1'b0;
        chk_eq("t3_halt_ce", 32'(io.cpu_ce), 0);
        chk_eq("t3_halt_st", 32'(io.state_o), 3);
        io.step_btn = 1'b1;
        count_ce(10, c);
        io.step_btn = 1'b0;
        count_ce(8, c2);
        chk_eq("t3_step_ign", 32'(c + c2), 0);
        chk_eq("t3_hold_st", 32'(io.state_o), 3);
        io.resume_btn = 1'b1;
        wait_ce(20, n);
        chk_eq("t3_res_lat", 32'(n), 6);
        chk_eq("t3_res_st", 32'(io.state_o), 2);
        tick();
        chk_eq("t3_res_idle", 32'(io.state_o), 0);
        chk_eq("t3_cnt", 32'(io.cycle_cnt), exp_cnt(5));
        tick();
        chk_eq("t3_res_run", 32'(io.state_o), 1);
        io.resume_btn = 1'b0;

        // 4: switch to fast rate while div_cnt is 3
        wait_ce(20, n);
        chk_eq("t4_first", 32'(n), 5);
        tick();
        io.fast_sw = 1'b1;
        wait_ce(20, n);
        chk_eq("t4_switch", 32'(n), 4);
        wait_ce(20, n);
        chk_eq("t4_fast1", 32'(n), 2);
        wait_ce(20, n);
        chk_eq("t4_fast2", 32'(n), 2);

        // 6: nine pulses saturate the 3-bit counter
        tick();
        chk_eq("t6_sat", 32'(io.cycle_cnt), exp_cnt(9));
        chk_eq("t5_led_pre", 32'(io.led_clk), 1);

        // 5: reset on a tick cycle in RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_eq("t5_ce",    32'(io.cpu_ce),    0);
        chk_eq("t5_led",   32'(io.led_clk),   0);
        chk_eq("t5_cnt",   32'(io.cycle_cnt), 0);
        chk_eq("t5_state", 32'(io.state_o),   0);
        wait_ce(20, n);
        chk_eq("t5_restart", 32'(n), 5);
        tick();
        chk_eq("t5_cnt_after", 32'(io.cycle_cnt), exp_cnt(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
